// File: rtl/mini_alu_stack_core_pkg.sv
// Shared opcode, state and instruction-field definitions for the mini ALU/stack core.
// Imported by the core and its return-stack helper.
package mini_alu_stack_core_pkg;

  localparam int INSTR_W  = 28;
  localparam int OP_MSB   = 27;
  localparam int OP_LSB   = 24;
  localparam int DST_MSB  = 23;
  localparam int DST_LSB  = 16;
  localparam int SRC1_MSB = 15;
  localparam int SRC1_LSB = 8;
  localparam int SRC0_MSB = 7;
  localparam int SRC0_LSB = 0;

  localparam logic [INSTR_W-1:0] INSTR_NOP = '0;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_SMUL = 4'h3,
    OP_STO  = 4'h4,
    OP_BLE  = 4'h5,
    OP_JMP  = 4'h6,
    OP_LED  = 4'h7,
    OP_CALL = 4'h8,
    OP_RET  = 4'h9,
    OP_KBRD = 4'hA,
    OP_HALT = 4'hF
  } op_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] dst;
    logic [7:0] src1;
    logic [7:0] src0;
  } instr_t;

  function automatic instr_t decode(input logic [INSTR_W-1:0] raw);
    instr_t d;
    d.op   = raw[OP_MSB:OP_LSB];
    d.dst  = raw[DST_MSB:DST_LSB];
    d.src1 = raw[SRC1_MSB:SRC1_LSB];
    d.src0 = raw[SRC0_MSB:SRC0_LSB];
    return d;
  endfunction

endpackage

// File: rtl/mac_return_stack.sv
// Bounded LIFO of return addresses; push is ignored when full, pop when empty.
// The top entry is presented combinationally so RET can redirect in the same cycle.
module mac_return_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  assign full   = (ptr_q == PTR_W'(DEPTH));
  assign empty  = (ptr_q == '0);
  assign wr_idx = IDX_W'(ptr_q);
  assign rd_idx = IDX_W'(ptr_q - 1'b1);
  assign top    = mem[rd_idx];

  always_comb begin
    ptr_d = ptr_q;
    if (push && !full) begin
      ptr_d = ptr_q + 1'b1;
    end else if (pop && !empty) begin
      ptr_d = ptr_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // NOTE: storage arrays carry no reset; only the pointer defines which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/mini_alu_stack_core.sv
// Two-stage (fetch/execute) mini core: ROM fetch, dual-read register file,
// bounded return stack, one-entry keycode buffer and a terminal HALT state.
module mini_alu_stack_core
  import mini_alu_stack_core_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int REG_ADDR_W  = 8,
  parameter int IP_W        = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic [IP_W-1:0]   oIP,
  input  logic [27:0]       iInstruction,
  input  logic              iKeyValid,
  input  logic [7:0]        iKeyCode,
  output logic [7:0]        oLed,
  output logic              oHalted,
  output logic              oStackErr,
  output logic              oKeyOverrun
);

  state_e             state_q, state_d;
  logic [IP_W-1:0]    ip_q, ip_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [7:0]         led_q, led_d;
  logic               stack_err_q, stack_err_d;
  logic               key_overrun_q, key_overrun_d;
  logic               key_pending_q, key_pending_d;
  logic [7:0]         key_code_q, key_code_d;

  logic [DATA_W-1:0]  rf [2**REG_ADDR_W];
  logic               rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]  rf_wdata;
  logic [DATA_W-1:0]  rs1, rs0, imm_ext;

  logic               stk_push, stk_pop, stk_full, stk_empty;
  logic [IP_W-1:0]    stk_top;

  logic               redirect, key_consume;
  logic [IP_W-1:0]    target;
  instr_t             d;

  assign d        = decode(ir_q);
  assign rf_waddr = d.dst[REG_ADDR_W-1:0];
  assign rs1      = rf[d.src1[REG_ADDR_W-1:0]];
  assign rs0      = rf[d.src0[REG_ADDR_W-1:0]];
  assign imm_ext  = DATA_W'($signed({d.src1, d.src0}));

  mac_return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (IP_W)
  ) u_return_stack (
    .clk       (Clock),
    .rst       (Reset),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (ip_q),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    ip_d          = ip_q;
    ir_d          = ir_q;
    led_d         = led_q;
    stack_err_d   = stack_err_q;
    key_overrun_d = key_overrun_q;
    key_pending_d = key_pending_q;
    key_code_d    = key_code_q;
    rf_we         = 1'b0;
    rf_wdata      = '0;
    stk_push      = 1'b0;
    stk_pop       = 1'b0;
    redirect      = 1'b0;
    key_consume   = 1'b0;
    target        = ip_q;

    if (state_q == ST_RUN) begin
      ir_d = iInstruction;
      ip_d = ip_q + 1'b1;
      // ip_q already points one past the executing instruction.
      case (d.op)
        OP_ADD:  begin rf_we = 1'b1; rf_wdata = rs1 + rs0; end
        OP_SUB:  begin rf_we = 1'b1; rf_wdata = rs1 - rs0; end
        OP_SMUL: begin rf_we = 1'b1; rf_wdata = DATA_W'($signed(rs1) * $signed(rs0)); end
        OP_STO:  begin rf_we = 1'b1; rf_wdata = imm_ext; end
        OP_BLE: begin
          if ($signed(rs1) <= $signed(rs0)) begin
            redirect = 1'b1;
            target   = IP_W'(d.dst);
          end
        end
        OP_JMP: begin
          redirect = 1'b1;
          target   = IP_W'(d.dst);
        end
        OP_LED: led_d = rs0[7:0];
        OP_CALL: begin
          if (stk_full) begin
            stack_err_d = 1'b1;
          end else begin
            stk_push = 1'b1;
            redirect = 1'b1;
            target   = IP_W'(d.dst);
          end
        end
        OP_RET: begin
          if (stk_empty) begin
            stack_err_d = 1'b1;
          end else begin
            stk_pop  = 1'b1;
            redirect = 1'b1;
            target   = stk_top;
          end
        end
        OP_KBRD: begin
          if (key_pending_q) begin
            rf_we       = 1'b1;
            rf_wdata    = DATA_W'(key_code_q);
            key_consume = 1'b1;
          end else begin
            redirect = 1'b1;
            target   = ip_q - 1'b1;
          end
        end
        OP_HALT: state_d = ST_HALT;
        default: ;
      endcase
      if (redirect) begin
        ip_d = target;
        ir_d = INSTR_NOP;
      end
    end

    // A same-cycle arrival while KBRD consumes refills the buffer without loss.
    if (iKeyValid) begin
      key_code_d    = iKeyCode;
      key_pending_d = 1'b1;
      if (key_pending_q && !key_consume) key_overrun_d = 1'b1;
    end else if (key_consume) begin
      key_pending_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q       <= ST_RUN;
      ip_q          <= '0;
      ir_q          <= INSTR_NOP;
      led_q         <= '0;
      stack_err_q   <= 1'b0;
      key_overrun_q <= 1'b0;
      key_pending_q <= 1'b0;
      key_code_q    <= '0;
    end else begin
      state_q       <= state_d;
      ip_q          <= ip_d;
      ir_q          <= ir_d;
      led_q         <= led_d;
      stack_err_q   <= stack_err_d;
      key_overrun_q <= key_overrun_d;
      key_pending_q <= key_pending_d;
      key_code_q    <= key_code_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (rf_we) begin
      rf[rf_waddr] <= rf_wdata;
    end
  end

  assign oIP         = ip_q;
  assign oLed        = led_q;
  assign oHalted     = (state_q == ST_HALT);
  assign oStackErr   = stack_err_q;
  assign oKeyOverrun = key_overrun_q;

endmodule

// File: tb/tb_mini_alu_stack_core.sv
// Directed bench for mini_alu_stack_core: small ROM programs per scenario,
// outputs sampled on the falling edge and compared with hand-derived values.
module tb_mini_alu_stack_core;
  import mini_alu_stack_core_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] oIP;
  logic [27:0] iInstruction;
  logic        iKeyValid = 1'b0;
  logic [7:0]  iKeyCode = '0;
  logic [7:0]  oLed;
  logic        oHalted, oStackErr, oKeyOverrun;

  logic [27:0] rom [256];
  int          total = 0;
  int          bad   = 0;

  always #5 Clock = ~Clock;

  assign iInstruction = rom[oIP[7:0]];

  mini_alu_stack_core #(
    .DATA_W      (16),
    .REG_ADDR_W  (8),
    .IP_W        (16),
    .STACK_DEPTH (4)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .oIP          (oIP),
    .iInstruction (iInstruction),
    .iKeyValid    (iKeyValid),
    .iKeyCode     (iKeyCode),
    .oLed         (oLed),
    .oHalted      (oHalted),
    .oStackErr    (oStackErr),
    .oKeyOverrun  (oKeyOverrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] ins(input op_e op, input logic [7:0] dst,
                                      input logic [7:0] s1, input logic [7:0] s0);
    return {op, dst, s1, s0};
  endfunction

  function automatic logic [27:0] sto(input logic [7:0] dst, input logic [15:0] imm);
    return {OP_STO, dst, imm};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Holds reset for one cycle, checks reset state, releases on a falling edge.
  task automatic do_reset();
    Reset = 1'b1;
    iKeyValid = 1'b0;
    @(negedge Clock);
    check("rst_ip", oIP, 0);
    check("rst_led", oLed, 0);
    check("rst_halt", oHalted, 0);
    check("rst_serr", oStackErr, 0);
    check("rst_kovr", oKeyOverrun, 0);
    Reset = 1'b0;
  endtask

  initial begin
    // Arithmetic, LED and HALT; instruction k executes on posedge k+2.
    clear_rom();
    rom[0] = sto(8'd1, 16'd5);
    rom[1] = sto(8'd2, 16'hFFFD);
    rom[2] = ins(OP_ADD, 8'd3, 8'd1, 8'd2);
    rom[3] = ins(OP_LED, 8'd0, 8'd0, 8'd3);
    rom[4] = ins(OP_SUB, 8'd4, 8'd1, 8'd2);
    rom[5] = ins(OP_LED, 8'd0, 8'd0, 8'd4);
    rom[6] = ins(OP_SMUL, 8'd5, 8'd1, 8'd2);
    rom[7] = ins(OP_LED, 8'd0, 8'd0, 8'd5);
    rom[8] = ins(OP_HALT, 8'd0, 8'd0, 8'd0);
    do_reset();
    step(4);  check("add_led_early", oLed, 8'h00);
    step(1);  check("add_led", oLed, 8'h02);
    step(2);  check("sub_led", oLed, 8'h08);
    step(2);  check("smul_led", oLed, 8'hF1);
    check("pre_halt", oHalted, 0);
    step(1);  check("halted", oHalted, 1);
    step(2);  check("halt_ip_hold", oIP, 16'd10);
    check("halt_led_hold", oLed, 8'hF1);
    #2 Reset = 1'b1;
    #1;
    check("async_rst_halt", oHalted, 0);
    check("async_rst_ip", oIP, 0);
    check("async_rst_led", oLed, 0);

    // Taken/not-taken/equal BLE with a one-cycle bubble.
    clear_rom();
    rom[8'h00] = sto(8'd1, 16'd5);
    rom[8'h01] = sto(8'd2, 16'hFFFD);
    rom[8'h02] = ins(OP_BLE, 8'h10, 8'd2, 8'd1);
    rom[8'h03] = ins(OP_LED, 8'd0, 8'd0, 8'd1);
    rom[8'h10] = ins(OP_LED, 8'd0, 8'd0, 8'd2);
    rom[8'h11] = ins(OP_BLE, 8'h30, 8'd1, 8'd2);
    rom[8'h12] = ins(OP_LED, 8'd0, 8'd0, 8'd1);
    rom[8'h13] = ins(OP_BLE, 8'h20, 8'd1, 8'd1);
    rom[8'h14] = ins(OP_LED, 8'd0, 8'd0, 8'd2);
    rom[8'h20] = ins(OP_HALT, 8'd0, 8'd0, 8'd0);
    do_reset();
    step(4);  check("ble_taken_ip", oIP, 16'h0010);
    step(1);  check("ble_bubble_led", oLed, 8'h00);
    step(1);  check("ble_target_led", oLed, 8'hFD);
    step(2);  check("ble_nt_led", oLed, 8'h05);
    check("ble_nt_ip", oIP, 16'h0014);
    step(1);  check("ble_eq_ip", oIP, 16'h0020);
    step(2);  check("ble_eq_halt", oHalted, 1);
    check("ble_eq_led", oLed, 8'h05);

    // Nested CALLs to full depth, overflowing CALL, then LIFO returns.
    clear_rom();
    rom[8'h00] = ins(OP_CALL, 8'h10, 8'd0, 8'd0);
    rom[8'h01] = ins(OP_HALT, 8'd0, 8'd0, 8'd0);
    rom[8'h10] = ins(OP_CALL, 8'h20, 8'd0, 8'd0);
    rom[8'h11] = ins(OP_RET, 8'd0, 8'd0, 8'd0);
    rom[8'h20] = ins(OP_CALL, 8'h30, 8'd0, 8'd0);
    rom[8'h21] = ins(OP_RET, 8'd0, 8'd0, 8'd0);
    rom[8'h30] = ins(OP_CALL, 8'h40, 8'd0, 8'd0);
    rom[8'h31] = ins(OP_RET, 8'd0, 8'd0, 8'd0);
    rom[8'h40] = ins(OP_CALL, 8'h50, 8'd0, 8'd0);
    rom[8'h41] = ins(OP_RET, 8'd0, 8'd0, 8'd0);
    do_reset();
    step(2);  check("call1_ip", oIP, 16'h0010);
    step(2);  check("call2_ip", oIP, 16'h0020);
    step(2);  check("call3_ip", oIP, 16'h0030);
    step(2);  check("call4_ip", oIP, 16'h0040);
    check("call4_noerr", oStackErr, 0);
    step(2);  check("call5_err", oStackErr, 1);
    check("call5_seq_ip", oIP, 16'h0042);
    step(1);  check("ret1_ip", oIP, 16'h0031);
    step(2);  check("ret2_ip", oIP, 16'h0021);
    step(2);  check("ret3_ip", oIP, 16'h0011);
    step(2);  check("ret4_ip", oIP, 16'h0001);
    step(2);  check("call_halt", oHalted, 1);

    // RET on an empty stack.
    clear_rom();
    rom[0] = ins(OP_RET, 8'd0, 8'd0, 8'd0);
    rom[1] = ins(OP_HALT, 8'd0, 8'd0, 8'd0);
    do_reset();
    step(2);  check("uflow_err", oStackErr, 1);
    check("uflow_ip", oIP, 16'd2);
    step(1);  check("uflow_halt", oHalted, 1);

    // KBRD spins until a key arrives.
    clear_rom();
    rom[0] = ins(OP_KBRD, 8'd4, 8'd0, 8'd0);
    rom[1] = ins(OP_LED, 8'd0, 8'd0, 8'd4);
    rom[2] = ins(OP_HALT, 8'd0, 8'd0, 8'd0);
    do_reset();
    step(2);  check("kbrd_spin1_ip", oIP, 16'd0);
    step(2);  check("kbrd_spin2_ip", oIP, 16'd0);
    iKeyValid = 1'b1; iKeyCode = 8'h1C;
    step(1);  iKeyValid = 1'b0;
    check("kbrd_fetch_ip", oIP, 16'd1);
    step(2);  check("kbrd_led", oLed, 8'h1C);
    step(1);  check("kbrd_halt", oHalted, 1);
    check("kbrd_no_ovr", oKeyOverrun, 0);

    // Two keys before KBRD: overrun, second code wins.
    clear_rom();
    rom[3] = ins(OP_KBRD, 8'd5, 8'd0, 8'd0);
    rom[4] = ins(OP_LED, 8'd0, 8'd0, 8'd5);
    rom[5] = ins(OP_HALT, 8'd0, 8'd0, 8'd0);
    do_reset();
    iKeyValid = 1'b1; iKeyCode = 8'h11;
    step(1);  check("ovr_first", oKeyOverrun, 0);
    iKeyCode = 8'h22;
    step(1);  iKeyValid = 1'b0;
    check("ovr_second", oKeyOverrun, 1);
    step(4);  check("ovr_led", oLed, 8'h22);

    // Key arriving while KBRD consumes; then capture while halted.
    clear_rom();
    rom[1] = ins(OP_KBRD, 8'd5, 8'd0, 8'd0);
    rom[2] = ins(OP_LED, 8'd0, 8'd0, 8'd5);
    rom[3] = ins(OP_KBRD, 8'd6, 8'd0, 8'd0);
    rom[4] = ins(OP_LED, 8'd0, 8'd0, 8'd6);
    rom[5] = ins(OP_HALT, 8'd0, 8'd0, 8'd0);
    do_reset();
    iKeyValid = 1'b1; iKeyCode = 8'h33;
    step(1);  iKeyValid = 1'b0;
    step(1);  iKeyValid = 1'b1; iKeyCode = 8'h44;
    step(1);  iKeyValid = 1'b0;
    check("same_cyc_no_ovr", oKeyOverrun, 0);
    step(1);  check("same_cyc_old", oLed, 8'h33);
    step(2);  check("same_cyc_new", oLed, 8'h44);
    step(1);  check("same_cyc_halt", oHalted, 1);
    iKeyValid = 1'b1; iKeyCode = 8'h55;
    step(1);  iKeyCode = 8'h66;
    step(1);  iKeyValid = 1'b0;
    check("halt_capture_ovr", oKeyOverrun, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
